// File: rtl/pkt_fifo_ram_ctrl.sv
// FIFO controller for an external simple dual-port RAM with a 1-cycle registered read.
// Hides read latency behind a 2-entry output buffer. Optional level/almost_full via PKT_FIFO_LEVEL_EN.
module pkt_fifo_ram_ctrl #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int AFULL_THRESH = (1 << ADDR_WIDTH) - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_din,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic                  ram_re,
    input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef PKT_FIFO_LEVEL_EN
    ,
    output logic [ADDR_WIDTH+1:0] level,
    output logic                  almost_full
`endif
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [ADDR_WIDTH:0]   ram_cnt;
    logic [ADDR_WIDTH:0]   ram_cnt_nxt;
    logic                  inflight;
    logic [1:0]            obuf_cnt;
    logic [1:0]            obuf_cnt_nxt;
    logic [DATA_WIDTH-1:0] obuf0;
    logic [DATA_WIDTH-1:0] obuf1;
    logic                  push;
    logic                  pop;

    assign wr_ready  = !rst && (ram_cnt < DEPTH_CNT);
    assign push      = wr_valid && wr_ready;
    assign rd_valid  = (obuf_cnt != 2'd0);
    assign rd_data   = obuf0;
    assign pop       = rd_valid && rd_ready;

    assign ram_we    = push;
    assign ram_waddr = wptr;
    assign ram_din   = wr_data;
    assign ram_raddr = rptr;

    // Issue a read only if the buffer still has room once everything in flight lands.
    assign ram_re = !rst && (ram_cnt != '0) &&
                    (({1'b0, obuf_cnt} + {2'b00, inflight}) <= (3'd1 + {2'b00, pop}));

    always_comb begin
        ram_cnt_nxt  = ram_cnt + (ADDR_WIDTH + 1)'(push) - (ADDR_WIDTH + 1)'(ram_re);
        obuf_cnt_nxt = obuf_cnt + 2'(inflight) - 2'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr     <= '0;
            rptr     <= '0;
            ram_cnt  <= '0;
            inflight <= 1'b0;
            obuf_cnt <= 2'd0;
            obuf0    <= '0;
            obuf1    <= '0;
        end else begin
            if (push)
                wptr <= wptr + ADDR_WIDTH'(1);
            if (ram_re)
                rptr <= rptr + ADDR_WIDTH'(1);
            ram_cnt  <= ram_cnt_nxt;
            inflight <= ram_re;
            obuf_cnt <= obuf_cnt_nxt;

            // obuf0 is always the head; obuf1 only holds the second word.
            if (pop) begin
                if (obuf_cnt == 2'd2) begin
                    obuf0 <= obuf1;
                    if (inflight)
                        obuf1 <= ram_dout;
                end else if (inflight) begin
                    obuf0 <= ram_dout;
                end
            end else if (inflight) begin
                if (obuf_cnt == 2'd0)
                    obuf0 <= ram_dout;
                else
                    obuf1 <= ram_dout;
            end
        end
    end

`ifdef PKT_FIFO_LEVEL_EN
    logic [ADDR_WIDTH+1:0] level_nxt;

    assign level_nxt = (ADDR_WIDTH + 2)'(ram_cnt_nxt) + (ADDR_WIDTH + 2)'(ram_re) +
                       (ADDR_WIDTH + 2)'(obuf_cnt_nxt);

    // Registered from next-state values so level matches the current occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
        end else begin
            level       <= level_nxt;
            almost_full <= (level_nxt >= (ADDR_WIDTH + 2)'(AFULL_THRESH));
        end
    end
`endif

endmodule

// File: tb/tb_pkt_fifo_ram_ctrl.sv
// Self-checking bench for pkt_fifo_ram_ctrl: vector table, directed corner sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_pkt_fifo_ram_ctrl;
    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [DW-1:0] wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] ram_waddr;
    logic          ram_we;
    logic [DW-1:0] ram_din;
    logic [AW-1:0] ram_raddr;
    logic          ram_re;
    logic [DW-1:0] ram_dout = '0;
`ifdef PKT_FIFO_LEVEL_EN
    logic [AW+1:0] level;
    logic          almost_full;
`endif

    pkt_fifo_ram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AFULL_THRESH(14)) dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_din(ram_din),
        .ram_raddr(ram_raddr), .ram_re(ram_re), .ram_dout(ram_dout)
`ifdef PKT_FIFO_LEVEL_EN
        , .level(level), .almost_full(almost_full)
`endif
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we) mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= mem[ram_raddr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: ordered queue of accepted words.
    logic [DW-1:0] model_q[$];
    int pops_total = 0;

    always @(negedge clk) begin
        if (rst) begin
            model_q.delete();
        end else begin
            if (ram_we && ram_re)
                check("addr_collide", 64'(ram_raddr == ram_waddr), 64'd0);
            if (model_q.size() < DEPTH)
                check("wr_ready_room", 64'(wr_ready), 64'd1);
            if (model_q.size() >= DEPTH + 2)
                check("wr_ready_full", 64'(wr_ready), 64'd0);
            if (rd_valid)
                check("rd_valid_nonempty", 64'(model_q.size() != 0), 64'd1);
            if (rd_valid && rd_ready && model_q.size() != 0) begin
                check("pop_data", 64'(rd_data), 64'(model_q[0]));
                void'(model_q.pop_front());
                pops_total++;
            end
            if (wr_valid && wr_ready)
                model_q.push_back(wr_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic          rr;
        logic          e_wready;
        logic          e_re;
        logic          e_rvalid;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int acc, popped, cyc, first_re, t_push, t_first_pop, t_last_pop, pushed, p0;
        bit found;

        tbl[0]  = '{1'b1, 32'hA5A5_0001, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001};
        tbl[4]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b1, 32'hB000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[6]  = '{1'b1, 32'hB000_0001, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b1, 32'hB000_0000};
        tbl[9]  = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hB000_0000};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 1'b1, 32'hB000_0001};
        tbl[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0, 32'h0};

        // Reset state, with a push attempted while in reset.
        rst = 1'b1; wr_valid = 1'b1; wr_data = 32'hDEAD_BEEF; rd_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("rst_wr_ready", 64'(wr_ready), 64'd0);
        check("rst_ram_we", 64'(ram_we), 64'd0);
        check("rst_ram_re", 64'(ram_re), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        tick();
        rst = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;

        // Vector table: single-word latency and a two-word sequence.
        for (int i = 0; i < 12; i++) begin
            wr_valid = tbl[i].wv; wr_data = tbl[i].wd; rd_ready = tbl[i].rr;
            @(negedge clk);
            check($sformatf("vec%0d_wr_ready", i), 64'(wr_ready), 64'(tbl[i].e_wready));
            check($sformatf("vec%0d_ram_re", i), 64'(ram_re), 64'(tbl[i].e_re));
            check($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(tbl[i].e_rvalid));
            if (tbl[i].e_rvalid)
                check($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(tbl[i].e_rdata));
            tick();
        end

        // Fill to capacity DEPTH+2 with the consumer stalled.
        wr_valid = 1'b1; rd_ready = 1'b0; acc = 0;
        for (int c = 0; c < 60 && acc < 18; c++) begin
            wr_data = 32'(acc);
            @(negedge clk);
            if (wr_ready) acc++;
            tick();
        end
        for (int c = 0; c < 5; c++) begin
            wr_data = 32'hFFFF_0000;
            @(negedge clk);
            if (wr_ready) acc++;
            check("full_wr_ready", 64'(wr_ready), 64'd0);
            tick();
        end
        check("full_accepted", 64'(acc), 64'd18);

        // Drain: order 0..17, wr_ready back the cycle after the first read issue.
        wr_valid = 1'b0; rd_ready = 1'b1; popped = 0; first_re = -1;
        for (int c = 0; c < 60 && popped < 18; c++) begin
            @(negedge clk);
            if (first_re < 0 && ram_re) begin
                first_re = c;
                check("full_wr_ready_at_re", 64'(wr_ready), 64'd0);
            end else if (first_re >= 0 && c == first_re + 1) begin
                check("full_wr_ready_after_re", 64'(wr_ready), 64'd1);
            end
            if (rd_valid) begin
                check("full_order", 64'(rd_data), 64'(popped));
                popped++;
            end
            tick();
        end
        check("full_popped", 64'(popped), 64'd18);

        // Streaming: 100 words, one per cycle after the fill latency.
        wr_valid = 1'b1; rd_ready = 1'b1; acc = 0; popped = 0;
        t_push = -1; t_first_pop = -1; t_last_pop = -1;
        for (int c = 0; c < 300 && popped < 100; c++) begin
            wr_data = 32'h1000 + 32'(acc);
            if (acc >= 100) wr_valid = 1'b0;
            @(negedge clk);
            if (wr_valid && wr_ready) begin
                if (t_push < 0) t_push = c;
                acc++;
            end
            if (rd_valid) begin
                check("stream_order", 64'(rd_data), 64'(32'h1000 + 32'(popped)));
                if (t_first_pop < 0) t_first_pop = c;
                t_last_pop = c;
                popped++;
            end
            tick();
        end
        wr_valid = 1'b0;
        check("stream_popped", 64'(popped), 64'd100);
        check("stream_latency", 64'(t_first_pop - t_push), 64'd3);
        check("stream_throughput", 64'(t_last_pop - t_first_pop), 64'd99);

        // Reset mid-stream with words queued and a read in flight.
        rd_ready = 1'b0; wr_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_data = 32'h5000 + 32'(k);
            tick();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        @(negedge clk);
        check("rstmid_read_issued", 64'(ram_re), 64'd1);
        tick();
        rd_ready = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("rstmid_ram_re", 64'(ram_re), 64'd0);
        tick();
        rst = 1'b0; wr_valid = 1'b1; wr_data = 32'h1234; rd_ready = 1'b1;
        @(negedge clk);
        check("rstmid_rd_valid", 64'(rd_valid), 64'd0);
        check("rstmid_wr_ready", 64'(wr_ready), 64'd1);
        tick();
        wr_valid = 1'b0;
        found = 1'b0; cyc = 0;
        for (int c = 1; c < 12 && !found; c++) begin
            @(negedge clk);
            if (rd_valid) begin
                found = 1'b1; cyc = c;
                check("rstmid_first_word", 64'(rd_data), 64'h1234);
            end
            tick();
        end
        check("rstmid_found", 64'(found), 64'd1);
        check("rstmid_latency", 64'(cyc), 64'd3);

        // Randomized traffic against the reference model.
        pushed = 0; p0 = pops_total;
        for (int c = 0; c < 20000 && pushed < 2000; c++) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_data  = $urandom;
            rd_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (wr_valid && wr_ready) pushed++;
            tick();
        end
        wr_valid = 1'b0; rd_ready = 1'b1;
        for (int c = 0; c < 100 && model_q.size() != 0; c++) tick();
        tick();
        check("rand_pushed", 64'(pushed), 64'd2000);
        check("rand_drained", 64'(model_q.size()), 64'd0);
        check("rand_popped", 64'(pops_total - p0), 64'd2000);
        @(negedge clk);
        check("rand_rd_valid_end", 64'(rd_valid), 64'd0);

`ifdef PKT_FIFO_LEVEL_EN
        do_reset();
        @(negedge clk);
        check("lvl_reset", 64'(level), 64'd0);
        tick();
        rd_ready = 1'b0; wr_valid = 1'b1;
        for (int k = 0; k < 14; k++) begin
            wr_data = 32'h7000 + 32'(k);
            tick();
        end
        wr_valid = 1'b0;
        tick(); tick(); tick();
        @(negedge clk);
        check("lvl_14", 64'(level), 64'd14);
        check("afull_14", 64'(almost_full), 64'd1);
        tick();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        @(negedge clk);
        check("lvl_13", 64'(level), 64'd13);
        check("afull_13", 64'(almost_full), 64'd0);
        tick();
`else
        do_reset();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/pkt_fifo_ram_ctrl.md
Name: pkt_fifo_ram_ctrl

Overview:
- Synchronous FIFO controller that drives an external single-clock simple dual-port RAM through its write port (waddr/we/din) and read port (raddr/re/dout). It is the user side of that RAM interface.
- The RAM's registered read has 1-cycle latency. The controller hides this behind a ready/valid push interface and a first-word-fall-through ready/valid pop interface, using a 2-entry output buffer.
- Used in the packet router as the per-port packet word buffer.

Parameters:
- ADDR_WIDTH, 4: RAM address width; RAM depth DEPTH = 1<<ADDR_WIDTH.
- DATA_WIDTH, 32: word width.
- AFULL_THRESH, (1<<ADDR_WIDTH)-2: level at or above which almost_full asserts (optional feature only).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- wr_valid  in  1  push request.
- wr_ready  out  1  controller can accept a word.
- wr_data  in  DATA_WIDTH  push data.
- rd_valid  out  1  rd_data holds the oldest word.
- rd_ready  in  1  consumer takes the word.
- rd_data  out  DATA_WIDTH  head word.
- ram_waddr  out  ADDR_WIDTH  RAM write address.
- ram_we  out  1  RAM write enable.
- ram_din  out  DATA_WIDTH  RAM write data.
- ram_raddr  out  ADDR_WIDTH  RAM read address.
- ram_re  out  1  RAM read enable.
- ram_dout  in  DATA_WIDTH  RAM read data, valid the cycle after ram_re.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state:
  - wptr = rptr = 0, ram_cnt = 0, inflight = 0, obuf_cnt = 0.
  - rd_valid = 0; rd_data = 0.
  - While rst = 1: wr_ready = 0, ram_we = 0, ram_re = 0.
  - Reset mid-operation discards all contents, including any read in flight; ram_dout in the cycle after reset is ignored.
- Push side:
  - wr_ready = !rst && (ram_cnt < DEPTH).
  - push = wr_valid && wr_ready.
  - ram_we = push, ram_waddr = wptr, ram_din = wr_data (combinational).
  - wptr increments modulo DEPTH on push.
- Read issue:
  - pop = rd_valid && rd_ready.
  - ram_re = !rst && ram_cnt > 0 && (obuf_cnt + inflight - pop) <= 1.
  - ram_raddr = rptr; rptr increments modulo DEPTH on ram_re.
  - inflight <= ram_re.
  - ram_cnt += push - ram_re. Both in the same cycle leaves it unchanged.
- RAM access rules:
  - The controller never reads the address being written in the same cycle: raddr == waddr only when ram_cnt is 0 (no read) or DEPTH (no write). The RAM's same-address bypass is therefore never exercised and is not required.
  - A word written at edge t may be read from cycle t+1.
- Output buffer:
  - 2-entry FIFO. When inflight = 1, ram_dout is written into it at the clock edge.
  - rd_data/rd_valid come from registers at the buffer head.
  - obuf_cnt += inflight - pop, never exceeding 2 (guaranteed by the read-issue rule).
- Latency:
  - A word accepted in cycle t (empty FIFO, rd_ready = 1) is presented with rd_valid = 1 in cycle t+3.
  - Steady state sustains 1 push and 1 pop per cycle.
- Full/empty:
  - Total capacity is DEPTH + 2: up to DEPTH words in the RAM plus up to 2 in flight/output buffer.
  - wr_ready depends only on ram_cnt.
  - Pop on empty is impossible since rd_valid = 0.
- Wrap-around: pointers wrap from DEPTH-1 to 0 with no bubble.

Optional Feature:
- Macro: PKT_FIFO_LEVEL_EN.
- Defined:
  - Adds output level [ADDR_WIDTH+1:0] = ram_cnt + inflight + obuf_cnt, registered, reset 0.
  - Adds output almost_full = (level >= AFULL_THRESH), registered, reset 0.
- Undefined: neither port exists; no extra logic.

Test Plan:
- Reset, then a single push of 0xA5A5_0001 in cycle t with rd_ready = 1 -> rd_valid = 1 with rd_data = 0xA5A5_0001 in cycle t+3; rd_valid = 0 in cycle t+4.
- rd_ready = 0; push 0..17 back-to-back with ADDR_WIDTH = 4 -> 18 words accepted and wr_ready = 0 after the 18th. Then rd_ready = 1 -> words pop in order 0..17, and wr_ready returns the cycle after the first ram_re.
- Continuous push and pop of 100 incrementing words -> 1 word/cycle throughput after the 3-cycle fill, order preserved. Pointers wrap multiple times; ram_raddr never equals ram_waddr while ram_we && ram_re.
- Random wr_valid/rd_ready at 50% each, 2000 words -> scoreboard matches; obuf_cnt never exceeds 2; ram_dout is never dropped.
- Assert rst mid-stream with 7 words queued and a read in flight -> next cycle rd_valid = 0, wr_ready = 1. A subsequent push of 0x1234 is the first word popped.
- PKT_FIFO_LEVEL_EN defined, AFULL_THRESH = 14: push 14 words with rd_ready = 0 -> level reaches 14 and almost_full = 1. One pop -> level 13 and almost_full = 0.
